// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : arbiter FSM state (IDLE=0, GRANT_I=1, GRANT_D=2; 3 is illegal)
//   owner_e     : identity of the requester that last held the port
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the icache refill port and the
// data-side load/store port. A grant is held for a whole transaction: a full
// LINE_WORDS burst for the icache, a single word for the data port. Ties are
// broken round-robin against the last granted requester.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ic_req/ic_addr                icache refill request (held for the burst) and word address
//   ic_data/ic_valid              refill beat data and strobe
//   d_req/d_we/d_addr/d_wdata     data request (held until d_valid), write flag, address, write data
//   d_rdata/d_valid               read data (0 on writes) and completion strobe
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side
//   mem_data/mem_valid            memory response; mem_valid only meaningful while mem_req is high
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic [DATA_WIDTH-1:0] ic_data,
    output logic                  ic_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid
);

    localparam int unsigned          BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    arb_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    owner_e            last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= OWNER_D;   // icache wins the first tie after reset
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // icache wins if alone, or on a tie when the data port went last
                if (ic_req && (!d_req || last_q == OWNER_D)) begin
                    state_d = GRANT_I;
                    last_d  = OWNER_IC;
                    beat_d  = '0;
                end else if (d_req) begin
                    state_d = GRANT_D;
                    last_d  = OWNER_D;
                    beat_d  = '0;
                end
            end
            GRANT_I: begin
                if (!ic_req) begin
                    // invalidate abort: a coincident mem_valid is discarded
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (mem_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            GRANT_D: begin
                if (!d_req || mem_valid) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_valid  = 1'b0;
        ic_data   = '0;
        d_valid   = 1'b0;
        d_rdata   = '0;
        case (state_q)
            GRANT_I: begin
                mem_req  = ic_req;
                mem_addr = ic_addr;
                // gating with the request keeps an aborted beat from leaking out
                ic_valid = ic_req & mem_valid;
                ic_data  = ic_req ? mem_data : '0;
            end
            GRANT_D: begin
                mem_req   = d_req;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_valid   = d_req & mem_valid;
                d_rdata   = (d_req && !d_we) ? mem_data : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_data;
    logic          ic_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_data;
    logic          mem_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LINE_WORDS(LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_data   (ic_data),
        .ic_valid  (ic_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_data  (mem_data),
        .mem_valid (mem_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, ".mem_req"},   64'(mem_req),   64'd0);
        chk({tag, ".mem_we"},    64'(mem_we),    64'd0);
        chk({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, ".ic_valid"},  64'(ic_valid),  64'd0);
        chk({tag, ".ic_data"},   64'(ic_data),   64'd0);
        chk({tag, ".d_valid"},   64'(d_valid),   64'd0);
        chk({tag, ".d_rdata"},   64'(d_rdata),   64'd0);
    endtask

    // Runs a full zero-wait icache burst starting in GRANT_I; leaves the bench one cycle after the last beat.
    task automatic ic_burst(input string tag, input logic [AW-1:0] base, input logic [DW-1:0] dbase);
        pulses = 0;
        for (int k = 0; k < int'(LW); k++) begin
            ic_addr   = base + AW'(4 * k);
            mem_data  = dbase + DW'(k);
            mem_valid = 1'b1;
            #1;
            chk({tag, ".mem_req"},  64'(mem_req),  64'd1);
            chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(base + AW'(4 * k)));
            chk({tag, ".mem_we"},   64'(mem_we),   64'd0);
            chk({tag, ".ic_data"},  64'(ic_data),  64'(dbase + DW'(k)));
            chk({tag, ".d_valid"},  64'(d_valid),  64'd0);
            chk({tag, ".d_rdata"},  64'(d_rdata),  64'd0);
            if (ic_valid) pulses++;
            tick();
        end
        mem_valid = 1'b0;
        chk({tag, ".pulses"}, 64'(pulses), 64'(LW));
    endtask

    initial begin
        rst = 1'b1; ic_req = 0; ic_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; mem_data = '0; mem_valid = 0;
        #2;
        outs_zero("reset");
        tick(); tick();
        rst = 1'b0;

        // --- icache only: 4 beats 0x100..0x10C, data 0xA0..0xA3
        ic_req = 1; ic_addr = 32'h100; #1;
        chk("t1.no_same_cycle_grant", 64'(mem_req), 64'd0);
        tick();
        ic_burst("t1", 32'h100, 32'hA0);
        chk("t1.idle_after_burst", 64'(mem_req), 64'd0);
        ic_req = 0; #1;
        outs_zero("t1.idle");
        tick();

        // --- simultaneous requests out of reset
        rst = 1; #1; rst = 0;
        ic_req = 1; ic_addr = 32'h800; d_req = 1; d_we = 0; d_addr = 32'h2000; #1;
        chk("t2.idle_mem_req", 64'(mem_req), 64'd0);
        tick();
        chk("t2.ic_first_addr", 64'(mem_addr), 64'h800);
        ic_burst("t2", 32'h800, 32'hB0);
        chk("t2.gap_mem_req", 64'(mem_req), 64'd0);
        tick();
        chk("t2.d_addr",   64'(mem_addr), 64'h2000);
        chk("t2.d_we",     64'(mem_we),   64'd0);
        mem_data = 32'hDEAD; mem_valid = 1; #1;
        chk("t2.d_valid",  64'(d_valid),  64'd1);
        chk("t2.d_rdata",  64'(d_rdata),  64'hDEAD);
        chk("t2.ic_valid_masked", 64'(ic_valid), 64'd0);
        chk("t2.ic_data_masked",  64'(ic_data),  64'd0);
        tick();
        mem_valid = 0; #1;
        chk("t2.d_valid_drop", 64'(d_valid), 64'd0);
        tick();   // tie again, data just finished -> icache
        chk("t2.tie_to_ic_addr", 64'(mem_addr), 64'(ic_addr));
        chk("t2.tie_to_ic_we",   64'(mem_we),   64'd0);
        ic_req = 0; d_req = 0; #1;
        chk("t2.abort_mem_req", 64'(mem_req), 64'd0);
        tick();

        // --- data write raised during an icache burst
        ic_req = 1; ic_addr = 32'h200;
        tick();
        ic_addr = 32'h200; mem_data = 32'hC0; mem_valid = 1;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h55AA;
        for (int k = 1; k < int'(LW); k++) begin
            ic_addr = 32'h200 + 32'(4 * k); mem_data = 32'hC0 + 32'(k); #1;
            chk("t3.we_held_off", 64'(mem_we),   64'd0);
            chk("t3.ic_owns",     64'(mem_addr), 64'(32'h200 + 32'(4 * k)));
            tick();
        end
        mem_valid = 0; ic_req = 0; #1;
        chk("t3.gap_mem_req", 64'(mem_req), 64'd0);
        chk("t3.gap_d_valid", 64'(d_valid), 64'd0);
        tick();
        chk("t3.mem_we",    64'(mem_we),    64'd1);
        chk("t3.mem_addr",  64'(mem_addr),  64'h3000);
        chk("t3.mem_wdata", 64'(mem_wdata), 64'h55AA);
        mem_data = 32'h1234; mem_valid = 1; #1;
        chk("t3.d_valid",   64'(d_valid),   64'd1);
        chk("t3.d_rdata_w", 64'(d_rdata),   64'd0);
        tick();
        d_req = 0; d_we = 0; mem_valid = 0; #1;
        chk("t3.d_valid_once", 64'(d_valid), 64'd0);
        tick();

        // --- abort after beat 2, then a full restart
        ic_req = 1; ic_addr = 32'h400;
        tick();
        for (int k = 0; k < 2; k++) begin
            ic_addr = 32'h400 + 32'(4 * k); mem_data = 32'hE0 + 32'(k); mem_valid = 1;
            tick();
        end
        ic_req = 0; mem_valid = 1; mem_data = 32'hEE; #1;
        chk("t4.abort_mem_req",  64'(mem_req),  64'd0);
        chk("t4.abort_ic_valid", 64'(ic_valid), 64'd0);
        chk("t4.abort_ic_data",  64'(ic_data),  64'd0);
        tick();
        mem_valid = 0; ic_req = 1; ic_addr = 32'h400; #1;
        chk("t4.idle_mem_req", 64'(mem_req), 64'd0);
        tick();
        ic_burst("t4.restart", 32'h400, 32'hF0);
        chk("t4.idle_after", 64'(mem_req), 64'd0);
        ic_req = 0;
        tick();

        // --- 3 wait states per beat
        ic_req = 1; ic_addr = 32'h500;
        tick();
        pulses = 0;
        for (int k = 0; k < int'(LW); k++) begin
            ic_addr = 32'h500 + 32'(4 * k);
            for (int s = 0; s < 3; s++) begin
                mem_valid = 0; #1;
                chk("t5.stall_addr", 64'(mem_addr), 64'(32'h500 + 32'(4 * k)));
                chk("t5.stall_we",   64'(mem_we),   64'd0);
                chk("t5.stall_req",  64'(mem_req),  64'd1);
                if (ic_valid) pulses++;
                tick();
            end
            mem_valid = 1; mem_data = 32'h50 + 32'(k); #1;
            if (ic_valid) pulses++;
            tick();
        end
        mem_valid = 0;
        chk("t5.pulses", 64'(pulses), 64'(LW));
        chk("t5.idle",   64'(mem_req), 64'd0);
        ic_req = 0;
        tick();

        // --- async reset mid-burst; last grant was icache, reset must restore icache priority
        ic_req = 1; ic_addr = 32'h600;
        tick();
        mem_valid = 1; mem_data = 32'h66;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h7000; d_wdata = 32'h77;
        #2;
        rst = 1; #1;
        outs_zero("t6.async");
        #2;
        rst = 0; mem_valid = 0;
        tick();
        chk("t6.tie_ic_addr", 64'(mem_addr), 64'h600);
        chk("t6.tie_ic_we",   64'(mem_we),   64'd0);
        ic_req = 0; d_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
